// File: rtl/lfsr_write_engine.sv
// rtl/lfsr_write_engine.sv - LFSR-addressed byte write engine for the associative-memory load path
//
// Accepts bytes on In_Valid/In_Ready and writes each one to the next address of a
// 16-bit Galois LFSR (taps 16'hB400, right shift). The search side replays the same
// sequence from the same seed. WR_Count reports the completed writes in this session.
//
// Optional feature macro: LFSR_WR_VERIFY_EN
//   defined     : every write is followed by a read-back (Mem_RD); a mismatch sets Error
//   not defined : Mem_RD = 0, Mem_Rdata ignored, Error = 0
//
// Ports:
//   Clock, Reset           : clock, asynchronous active-low reset
//   Start, Stop            : one-cycle session control pulses
//   In_Valid/In_Data       : byte stream in; In_Ready = engine accepts this cycle
//   Mem_Addr/Mem_Data      : memory address (LFSR) and write data
//   Mem_WR/Mem_RD/Mem_Ack  : request held until Mem_Ack; Mem_Rdata read-back data
//   WR_Count/Full/Busy     : session status; Error sticky read-back mismatch
module lfsr_write_engine #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 8,
  parameter logic [ADDR_W-1:0] SEED   = 16'h0001
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_RD,
  input  logic [DATA_W-1:0] Mem_Rdata,
  input  logic              Mem_Ack,
  output logic [15:0]       WR_Count,
  output logic              Full,
  output logic              Busy,
  output logic              Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_VERIFY,
    S_ADVANCE,
    S_FULL
  } state_t;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [ADDR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
  localparam logic [ADDR_W-1:0] POLY     = 16'hB400;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   lfsr_q, lfsr_d;
  logic [15:0]         count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                full_q, full_d;
  logic                error_q, error_d;
  logic                mem_wr, mem_rd;
  logic [ADDR_W-1:0]   lfsr_next;

  assign lfsr_next = {1'b0, lfsr_q[ADDR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);

`ifndef LFSR_WR_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^Mem_Rdata;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      count_q <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      data_q  <= data_d;
      full_q  <= full_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    data_d  = data_q;
    full_d  = full_q;
    error_d = error_q;
    mem_wr  = 1'b0;
    mem_rd  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          lfsr_d  = SEED_EFF;
          count_d = '0;
          full_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        // Stop wins over a same-cycle byte; In_Ready is already low then.
        if (Stop) begin
          state_d = S_IDLE;
        end else if (In_Valid) begin
          data_d  = In_Data;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        mem_wr = 1'b1;
        if (Mem_Ack) begin
`ifdef LFSR_WR_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_ADVANCE;
`endif
        end
      end

`ifdef LFSR_WR_VERIFY_EN
      S_VERIFY: begin
        mem_rd = 1'b1;
        if (Mem_Ack) begin
          if (Mem_Rdata != data_q) begin
            error_d = 1'b1;
          end
          state_d = S_ADVANCE;
        end
      end
`endif

      S_ADVANCE: begin
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        lfsr_d = lfsr_next;
        // The 65535th write exhausts the LFSR period.
        if (count_q == 16'hFFFE) begin
          full_d  = 1'b1;
          state_d = S_FULL;
        end else begin
          state_d = S_ACCEPT;
        end
      end

      S_FULL: begin
        if (Start) begin
          lfsr_d  = SEED_EFF;
          count_d = '0;
          full_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_ACCEPT;
        end else if (Stop) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Busy     = (state_q != S_IDLE);
  assign In_Ready = (state_q == S_ACCEPT) && !Stop;
  assign Mem_WR   = mem_wr;
  assign Mem_RD   = mem_rd;
  // Address is forced to zero while idle so the port is quiet out of reset.
  assign Mem_Addr = Busy ? lfsr_q : '0;
  assign Mem_Data = data_q;
  assign WR_Count = count_q;
  assign Full     = full_q;
  assign Error    = error_q;

endmodule
